// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Reader side of the combinational instruction memory. A program counter
//   drives imem_addr, and each returned word is captured with its PC into a
//   small prefetch FIFO. Decode drains the FIFO over a valid/ready handshake.
//   A branch redirect flushes the FIFO and reloads the PC.
//
//   Optional feature macro: IFETCH_ZERO_HALT_EN
//     When defined, fetching an all-zero word stops the prefetcher in a HALT
//     state until the next branch redirect.
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 17,
    parameter int PC_STEP    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

`ifdef IFETCH_ZERO_HALT_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pushEn;
    logic               popEn;

    logic [INSTR_W-1:0] dataMem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pcMem_q   [FIFO_DEPTH];

    // Next-state logic: branch redirect wins over everything; otherwise the
    // FSM steps and the FIFO takes a push and/or pop. A pop never frees a slot
    // for a push in the same cycle, so the push check uses the old count.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pushEn    = 1'b0;
        popEn     = 1'b0;

        if (branch_valid) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            fetchPc_d = {branch_target[ADDR_W-1:2], 2'b00};
            state_d   = fetch_en ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en)  state_d = RUN;
                RUN:     if (!fetch_en) state_d = IDLE;
                default: state_d = state_q;
            endcase

            pushEn = (state_q == RUN) && (count_q < DEPTH_C);
            popEn  = (count_q != '0) && instr_ready;

            if (pushEn) begin
                tail_d    = tail_q + PTR_W'(1);
                fetchPc_d = fetchPc_q + STEP_C;
`ifdef IFETCH_ZERO_HALT_EN
                if (imem_data == '0) state_d = HALT;
`endif
            end
            if (popEn) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
        end
    end

    // Control state register; reset drops any buffered instructions at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fetchPc_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage: captures the fetched word with its PC at the tail slot.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            dataMem_q[tail_q] <= imem_data;
            pcMem_q[tail_q]   <= fetchPc_q;
        end
    end

    assign imem_addr   = fetchPc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? dataMem_q[head_q] : '0;
    assign instr_pc    = instr_valid ? pcMem_q[head_q]   : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed scenarios followed by random traffic, all checked every cycle
//   against a queue-based model of the fetch unit. Directed scenarios also
//   pin a few literal expectations.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [16:0] imem_data;
    logic        branch_valid;
    logic [7:0]  branch_target;
    logic        instr_valid;
    logic [16:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] mem [64];

    // Model state: queue of {pc, word}, fetch PC and run/halt flags.
    logic [24:0] modelQ [$];
    logic [7:0]  modelPc;
    bit          modelRun;
    bit          modelHalt;

    instruction_fetch dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory, one word per 4-byte step.
    assign imem_data = mem[imem_addr[7:2]];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the sampled inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            modelPc   = 8'h00;
            modelRun  = 1'b0;
            modelHalt = 1'b0;
        end else if (branch_valid) begin
            modelQ.delete();
            modelPc   = branch_target & 8'hFC;
            modelHalt = 1'b0;
            modelRun  = fetch_en;
        end else if (!modelHalt) begin
            logic [16:0] word;
            bit          doPush;
            word   = mem[modelPc >> 2];
            doPush = modelRun && (modelQ.size() < 4);
            if (modelQ.size() != 0 && instr_ready) void'(modelQ.pop_front());
            if (doPush) begin
                modelQ.push_back({modelPc, word});
                modelPc = modelPc + 8'd4;
            end
            modelRun = fetch_en;
`ifdef IFETCH_ZERO_HALT_EN
            if (doPush && word == 17'h0) begin
                modelHalt = 1'b1;
                modelRun  = 1'b0;
            end
`endif
        end else begin
            if (modelQ.size() != 0 && instr_ready) void'(modelQ.pop_front());
        end
    end

    // Compare process: outputs settle well before the falling edge.
    always @(negedge clk) begin
        logic        expValid;
        logic [16:0] expData;
        logic [7:0]  expPc;
        expValid = (modelQ.size() != 0);
        expData  = expValid ? modelQ[0][16:0]  : 17'h0;
        expPc    = expValid ? modelQ[0][24:17] : 8'h00;
        checkOutput("imem_addr",   32'(imem_addr),   32'(modelPc));
        checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
        checkOutput("instr_data",  32'(instr_data),  32'(expData));
        checkOutput("instr_pc",    32'(instr_pc),    32'(expPc));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit en, input bit rdy, input bit br, input logic [7:0] tgt);
        fetch_en      = en;
        instr_ready   = rdy;
        branch_valid  = br;
        branch_target = tgt;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 17'($urandom) | 17'h1;
        mem[0]  = 17'h0F7FF;
        mem[1]  = 17'h04E22;
        mem[2]  = 17'h04E17;
        mem[11] = 17'h00000;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("reset_valid", 32'(instr_valid), 32'd0);
        checkOutput("reset_addr",  32'(imem_addr),   32'd0);
        tick();
        doReset();

        // Sequential fetch with decode always ready.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk); checkOutput("seq_valid_n0", 32'(instr_valid), 32'd0);
        @(negedge clk); checkOutput("seq_valid_n1", 32'(instr_valid), 32'd0);
        @(negedge clk); checkOutput("seq_pc0",   32'(instr_pc),   32'h00);
                        checkOutput("seq_data0", 32'(instr_data), 32'h0F7FF);
        @(negedge clk); checkOutput("seq_pc1",   32'(instr_pc),   32'h04);
                        checkOutput("seq_data1", 32'(instr_data), 32'h04E22);
        @(negedge clk); checkOutput("seq_pc2",   32'(instr_pc),   32'h08);
                        checkOutput("seq_data2", 32'(instr_data), 32'h04E17);

        // Back-pressure: FIFO fills and the PC stalls.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (8) tick();
        checkOutput("stall_addr", 32'(imem_addr),  32'h10);
        checkOutput("stall_pc",   32'(instr_pc),   32'h00);
        checkOutput("stall_data", 32'(instr_data), 32'h0F7FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk); checkOutput("release_pc", 32'(instr_pc), 32'h04);
        repeat (6) tick();

        // Branch to an unaligned target while three entries are buffered.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h1E);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk); checkOutput("br_valid", 32'(instr_valid), 32'd0);
                        checkOutput("br_addr",  32'(imem_addr),   32'h1C);
        @(negedge clk); checkOutput("br_pc",    32'(instr_pc),    32'h1C);

        // PC wrap through the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hF8);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk); checkOutput("wrap_valid", 32'(instr_valid), 32'd0);
        @(negedge clk); checkOutput("wrap_pc0", 32'(instr_pc), 32'hF8);
        @(negedge clk); checkOutput("wrap_pc1", 32'(instr_pc), 32'hFC);
        @(negedge clk); checkOutput("wrap_pc2", 32'(instr_pc), 32'h00);
        @(negedge clk); checkOutput("wrap_pc3", 32'(instr_pc), 32'h04);

`ifdef IFETCH_ZERO_HALT_EN
        // Zero word at 0x2C stops the prefetcher until a branch.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (10) tick();
        checkOutput("halt_addr", 32'(imem_addr), 32'h30);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) tick();
        checkOutput("resume_addr", 32'(imem_addr), 32'h0C);
`endif

        // Asynchronous reset with two entries buffered.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(instr_valid), 32'd0);
        checkOutput("arst_addr",  32'(imem_addr),   32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (3) tick();
        checkOutput("idle_addr", 32'(imem_addr), 32'd0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 24) == 0,
                          8'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
